// File: rtl/sprite_sched_pkg.sv
// Shared types and the row-hit helper for the per-scanline sprite scheduler.
// Sprite height is fixed here at 8 rows; the scheduler's SPRITE_H parameter must agree.
package sprite_sched_pkg;

  localparam int SPR_H = 8;
  localparam int RW    = $clog2(SPR_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]    code;
    logic [RW-1:0] row;
    logic [7:0]    x;
  } cand_t;

  typedef struct packed {
    logic          hit;
    logic [RW-1:0] row;
  } row_hit_t;

  // Row within the sprite for next_line; modulo-512 difference makes lines above y wrap to large values.
  function automatic row_hit_t row_hit(input logic [8:0] next_line, input logic [7:0] y);
    row_hit_t   r;
    logic [8:0] d;
    d     = next_line - {1'b0, y};
    r.hit = (d < 9'(SPR_H));
    r.row = d[RW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sprite_line_scheduler.sv
// Hblank sprite scheduler: scans the attribute table for the next line, then loads up to NUM_SLOTS renderers.
// Trigger-to-idle takes NUM_SPRITES+3 cycles with no hits, plus cand_cnt+1 fetch cycles otherwise; no backpressure.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int NUM_SLOTS   = 4,
  parameter int SPRITE_H    = 8,
  parameter int SCAN_HPOS   = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [8:0]                       hpos,
  input  logic [8:0]                       vpos,
  output logic [$clog2(NUM_SPRITES)-1:0]   spr_idx,
  input  logic [7:0]                       spr_x,
  input  logic [7:0]                       spr_y,
  input  logic [3:0]                       spr_code,
  output logic [3+$clog2(SPRITE_H):0]      rom_addr,
  input  logic [7:0]                       rom_data,
  output logic [NUM_SLOTS-1:0]             slot_load,
  output logic [7:0]                       slot_x,
  output logic [7:0]                       slot_bits,
  output logic [NUM_SLOTS-1:0]             slot_valid,
  output logic                             busy,
  output logic                             overflow
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(NUM_SPRITES + 1);
  localparam int KW = $clog2(NUM_SLOTS + 1);
  localparam int SW = $clog2(NUM_SLOTS);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_m1;
  logic [KW-1:0] cand_cnt;
  logic [8:0]    next_line;
  cand_t         cand [NUM_SLOTS];

  row_hit_t      hr;
  logic          scan_hit;
  logic          trigger;
  logic [SW-1:0] fidx;
  logic [SW-1:0] pidx;

  assign trigger = (hpos == 9'(SCAN_HPOS));
  assign cnt_m1  = cnt - 1'b1;
  assign fidx    = cnt[SW-1:0];
  assign pidx    = cnt_m1[SW-1:0];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    spr_idx   = '0;
    rom_addr  = '0;
    slot_load = '0;
    slot_x    = '0;
    slot_bits = '0;
    hr        = row_hit(next_line, spr_y);
    scan_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = SCAN;
      end
      SCAN: begin
        if (cnt < CW'(NUM_SPRITES)) spr_idx = cnt[IW-1:0];
        // Attribute data lags the address by one cycle, so cnt evaluates entry cnt-1.
        scan_hit = (cnt != '0) && hr.hit;
        if (cnt == CW'(NUM_SPRITES))
          state_nxt = ((cand_cnt != '0) || scan_hit) ? FETCH : DONE;
      end
      FETCH: begin
        if (cnt < CW'(cand_cnt)) rom_addr = {cand[fidx].code, cand[fidx].row};
        if (cnt != '0) begin
          slot_load = NUM_SLOTS'(1) << pidx;
          slot_x    = cand[pidx].x;
          slot_bits = rom_data;
        end
        if (cnt == CW'(cand_cnt)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cand_cnt   <= '0;
      next_line  <= '0;
      slot_valid <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (trigger) begin
            next_line <= vpos + 9'd1;
            cnt       <= '0;
            cand_cnt  <= '0;
            overflow  <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            if (cand_cnt < KW'(NUM_SLOTS)) begin
              cand[cand_cnt[SW-1:0]] <= {spr_code, hr.row, spr_x};
              cand_cnt               <= cand_cnt + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          cnt <= (cnt == CW'(NUM_SPRITES)) ? '0 : cnt + 1'b1;
        end
        FETCH: begin
          cnt <= (cnt == CW'(cand_cnt)) ? '0 : cnt + 1'b1;
        end
        DONE: begin
          slot_valid <= NUM_SLOTS'((1 << cand_cnt) - 1);
          cnt        <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with behavioural attribute RAM and sprite ROM.
module tb_sprite_line_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic [3:0] spr_idx;
  logic [7:0] spr_x = '0, spr_y = '0;
  logic [3:0] spr_code = '0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [3:0] slot_load, slot_valid;
  logic [7:0] slot_x, slot_bits;
  logic       busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ax [16];
  logic [7:0] ay [16];
  logic [3:0] ac [16];

  // Results captured by run_scan
  int         n_loads, cycles;
  logic       first_busy, timeout;
  logic [3:0] ld_vec  [8];
  logic [7:0] ld_x    [8];
  logic [7:0] ld_bits [8];
  logic [6:0] ld_addr [8];

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .spr_idx(spr_idx), .spr_x(spr_x), .spr_y(spr_y), .spr_code(spr_code),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .slot_load(slot_load), .slot_x(slot_x), .slot_bits(slot_bits),
    .slot_valid(slot_valid), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [6:0] a);
    return {a, 1'b0} ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    spr_x    <= ax[spr_idx];
    spr_y    <= ay[spr_idx];
    spr_code <= ac[spr_idx];
    rom_data <= rom_fn(rom_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_attrs;
    for (int i = 0; i < 16; i++) begin
      ax[i] = 8'd0;
      ay[i] = 8'd200;
      ac[i] = 4'd0;
    end
  endtask

  // One trigger cycle, then sample every busy cycle until the block is idle again.
  task automatic run_scan(input logic [8:0] v);
    logic [6:0] prev_addr;
    hpos = 9'd256;
    vpos = v;
    tick;
    hpos = 9'd0;
    first_busy = busy;
    n_loads    = 0;
    cycles     = 1;
    prev_addr  = '0;
    for (int g = 0; g < 60 && busy; g++) begin
      cycles++;
      if (slot_load != 4'd0 && n_loads < 8) begin
        ld_vec[n_loads]  = slot_load;
        ld_x[n_loads]    = slot_x;
        ld_bits[n_loads] = slot_bits;
        ld_addr[n_loads] = prev_addr;
        n_loads++;
      end
      prev_addr = rom_addr;
      tick;
    end
    timeout = busy;
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL scan_timeout: busy still %b after 60 cycles", busy); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    hpos  = 9'd256;
    vpos  = 9'd0;
    clear_attrs();
    repeat (7) tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({spr_idx, rom_addr} !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %h/%h expected 0/0", spr_idx, rom_addr); end
    n_checks++; if ({slot_load, slot_x, slot_bits} !== 20'd0) begin n_fail++; $display("FAIL reset_slot: got %b/%h/%h expected 0", slot_load, slot_x, slot_bits); end
    n_checks++; if ({slot_valid, overflow} !== 5'd0) begin n_fail++; $display("FAIL reset_valid_ovf: got %b/%b expected 0000/0", slot_valid, overflow); end
    reset = 1'b0;
    hpos  = 9'd0;
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", busy); end
    run_scan(9'd10);
    n_checks++; if (first_busy !== 1'b1) begin n_fail++; $display("FAIL first_trigger_busy: got %b expected 1", first_busy); end
  endtask

  task automatic test_single_hit;
    clear_attrs();
    ax[3] = 8'd40; ay[3] = 8'd96; ac[3] = 4'd5;
    run_scan(9'd99);
    n_checks++; if (n_loads !== 1) begin n_fail++; $display("FAIL single_nloads: got %0d expected 1", n_loads); end
    n_checks++; if (ld_vec[0] !== 4'b0001) begin n_fail++; $display("FAIL single_load_vec: got %b expected 0001", ld_vec[0]); end
    n_checks++; if (ld_addr[0] !== 7'h2C) begin n_fail++; $display("FAIL single_rom_addr: got %h expected 2c", ld_addr[0]); end
    n_checks++; if (ld_x[0] !== 8'd40) begin n_fail++; $display("FAIL single_x: got %0d expected 40", ld_x[0]); end
    n_checks++; if (ld_bits[0] !== rom_fn(7'h2C)) begin n_fail++; $display("FAIL single_bits: got %h expected %h", ld_bits[0], rom_fn(7'h2C)); end
    n_checks++; if (slot_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b expected 0001", slot_valid); end
    n_checks++; if (cycles !== 21) begin n_fail++; $display("FAIL single_cycles: got %0d expected 21", cycles); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b expected 0", overflow); end
  endtask

  task automatic setup_overflow;
    int hits [5];
    hits = '{1, 2, 5, 9, 12};
    clear_attrs();
    for (int k = 0; k < 5; k++) begin
      ax[hits[k]] = 8'(16 * hits[k] + 3);
      ay[hits[k]] = 8'd51;
      ac[hits[k]] = 4'(hits[k]);
    end
  endtask

  task automatic check_overflow_result(input string tag);
    int hits [4];
    logic [6:0] ea;
    hits = '{1, 2, 5, 9};
    n_checks++; if (n_loads !== 4) begin n_fail++; $display("FAIL %s_nloads: got %0d expected 4", tag, n_loads); end
    for (int k = 0; k < 4 && k < n_loads; k++) begin
      ea = {4'(hits[k]), 3'd0};
      n_checks++;
      if (ld_vec[k] !== 4'(1 << k) || ld_x[k] !== 8'(16 * hits[k] + 3) || ld_addr[k] !== ea || ld_bits[k] !== rom_fn(ea)) begin
        n_fail++;
        $display("FAIL %s_load%0d: got vec=%b x=%0d addr=%h bits=%h expected vec=%b x=%0d addr=%h bits=%h",
                 tag, k, ld_vec[k], ld_x[k], ld_addr[k], ld_bits[k], 4'(1 << k), 8'(16 * hits[k] + 3), ea, rom_fn(ea));
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL %s_overflow: got %b expected 1", tag, overflow); end
    n_checks++; if (slot_valid !== 4'b1111) begin n_fail++; $display("FAIL %s_valid: got %b expected 1111", tag, slot_valid); end
    n_checks++; if (cycles !== 24) begin n_fail++; $display("FAIL %s_cycles: got %0d expected 24", tag, cycles); end
  endtask

  task automatic test_overflow;
    setup_overflow();
    run_scan(9'd50);
    check_overflow_result("ovf");
    tick;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
  endtask

  task automatic test_no_hit;
    clear_attrs();
    run_scan(9'd10);
    n_checks++; if (n_loads !== 0) begin n_fail++; $display("FAIL nohit_nloads: got %0d expected 0", n_loads); end
    n_checks++; if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL nohit_valid: got %b expected 0000", slot_valid); end
    n_checks++; if (cycles !== 19) begin n_fail++; $display("FAIL nohit_cycles: got %0d expected 19", cycles); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL nohit_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_wrap;
    clear_attrs();
    ax[0] = 8'd7; ay[0] = 8'd255; ac[0] = 4'd9;
    run_scan(9'd261);
    n_checks++; if (n_loads !== 1 || ld_addr[0] !== 7'h4F || ld_x[0] !== 8'd7) begin
      n_fail++; $display("FAIL wrap_row7: got n=%0d addr=%h x=%0d expected n=1 addr=4f x=7", n_loads, ld_addr[0], ld_x[0]); end
    n_checks++; if (slot_valid !== 4'b0001) begin n_fail++; $display("FAIL wrap_row7_valid: got %b expected 0001", slot_valid); end
    run_scan(9'd262);
    n_checks++; if (n_loads !== 0 || slot_valid !== 4'b0000) begin
      n_fail++; $display("FAIL wrap_row8: got n=%0d valid=%b expected n=0 valid=0000", n_loads, slot_valid); end
    ay[0] = 8'd0;
    run_scan(9'd511);
    n_checks++; if (n_loads !== 1 || ld_addr[0] !== 7'h48) begin
      n_fail++; $display("FAIL wrap_line0: got n=%0d addr=%h expected n=1 addr=48", n_loads, ld_addr[0]); end
  endtask

  task automatic test_reset_mid_scan;
    logic saw_load;
    setup_overflow();
    hpos = 9'd256;
    vpos = 9'd50;
    tick;
    hpos = 9'd0;
    repeat (4) tick;
    reset = 1'b1;
    hpos  = 9'd256;
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if ({spr_idx, rom_addr, slot_load, slot_x, slot_bits, slot_valid, overflow} !== 36'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got idx=%h addr=%h ld=%b x=%h bits=%h valid=%b ovf=%b expected all 0",
                         spr_idx, rom_addr, slot_load, slot_x, slot_bits, slot_valid, overflow); end
    reset = 1'b0;
    hpos  = 9'd0;
    saw_load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (slot_load != 4'd0 || busy) saw_load = 1'b1;
      tick;
    end
    n_checks++; if (saw_load !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: got activity=%b expected 0", saw_load); end
    run_scan(9'd50);
    check_overflow_result("after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_overflow();
    test_no_hit();
    test_wrap();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sprite scheduler for the sprite test / tile-render video path. During horizontal blank it scans the sprite attribute table for sprites that cover the next scanline and selects up to NUM_SLOTS of them, lowest index first. It fetches each selected sprite's row bitmap from the shared sprite ROM and loads it into one of the per-slot sprite renderers. It sits between the sync generator (hpos/vpos), the attribute RAM, the sprite ROM, and the renderer slots whose outputs are mixed into rgb.

## Interface
Parameters:
- NUM_SPRITES, 16, attribute table entries; index width IW = $clog2(NUM_SPRITES)
- NUM_SLOTS, 4, renderer slots
- SPRITE_H, 8, sprite height in rows; RW = $clog2(SPRITE_H)
- SCAN_HPOS, 256, hpos value that triggers a scan

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, all state sampled on rising edge of clk
- hpos  in  9  current horizontal position
- vpos  in  9  current scanline
- spr_idx  out  IW  attribute RAM read address
- spr_x  in  8  attribute x, valid 1 cycle after spr_idx
- spr_y  in  8  attribute y (top row), same latency
- spr_code  in  4  bitmap code, same latency
- rom_addr  out  4+RW  sprite ROM address = {code, row}
- rom_data  in  8  ROM row bits, valid 1 cycle after rom_addr
- slot_load  out  NUM_SLOTS  one-hot, 1-cycle load strobe
- slot_x  out  8  x position for the loaded slot
- slot_bits  out  8  row bitmap for the loaded slot
- slot_valid  out  NUM_SLOTS  slot k holds a sprite for the upcoming line
- busy  out  1  high outside IDLE
- overflow  out  1  more than NUM_SLOTS hits on the last scanned line

## Operation
- States: IDLE, SCAN, FETCH, DONE.
- **IDLE**:
  - On hpos == SCAN_HPOS, latch next_line = vpos + 1 (9-bit, wraps).
  - Clear cand_cnt, cnt and overflow, then go to SCAN.
  - The trigger is ignored in any other state.
- **SCAN**: counter cnt runs 0..NUM_SPRITES.
  - spr_idx = cnt while cnt < NUM_SPRITES; otherwise spr_idx holds 0.
  - When cnt ≥ 1, evaluate entry cnt-1 as follows:
    - row = next_line − {1'b0, spr_y}, modulo 2^9.
    - The entry is a hit iff row < SPRITE_H.
    - On a hit with cand_cnt < NUM_SLOTS, store {code, row[RW-1:0], x} in cand[cand_cnt] and increment cand_cnt.
    - On a hit with cand_cnt == NUM_SLOTS, set overflow.
  - When cnt == NUM_SPRITES: go to FETCH with cnt = 0 if cand_cnt > 0, else go to DONE.
- **FETCH**: cnt runs 0..cand_cnt.
  - rom_addr = {cand[cnt].code, cand[cnt].row} while cnt < cand_cnt.
  - When cnt ≥ 1: slot_load[cnt-1] = 1, slot_x = cand[cnt-1].x, slot_bits = rom_data.
  - When cnt == cand_cnt, go to DONE.
- **DONE**: slot_valid ← (1 << cand_cnt) − 1, then return to IDLE.
- slot_valid keeps its previous value from scan start until DONE. Renderers show the current line undisturbed.
- overflow holds until the next scan start.

## Timing
- Reset values: state IDLE, and every output 0 (spr_idx, rom_addr, slot_load, slot_x, slot_bits, slot_valid, busy, overflow).
- Total cycles from trigger edge to IDLE:
  - With hits: 1 + (NUM_SPRITES + 1) + (cand_cnt + 1) + 1.
  - With no hits: NUM_SPRITES + 3.
  - Defaults: 19 cycles minimum, 24 maximum. This must fit before the hblank ends.
- The slot_load strobes occur on consecutive cycles, slot 0 first.
- Unused slots receive no strobe.
- Reset asserted mid-SCAN or mid-FETCH:
  - Next cycle the block is in IDLE with all outputs 0.
  - No further strobes are issued.
  - A trigger on the reset-release cycle is ignored.
- next_line wraps from 511 to 0. A sprite with spr_y = 255 hits lines 255..262.

## Structure
- Package sprite_sched_pkg holds:
  - state_t enum
  - cand_t struct {code[3:0], row[RW-1:0], x[7:0]}
  - function row_hit(next_line, y) returning the hit flag and row
- The block needs no sub-module. Counters, candidate array and FSM live in one always_ff, plus comb decode.

## Test plan
- Reset held 7 cycles with hpos = 256 → all outputs 0 and busy = 0. After release, the first trigger at hpos = 256 sets busy the next cycle.
- vpos = 99, sprite 3 {x=40, y=96, code=5}, all others y=200 → exactly one hit:
  - rom_addr = {5, 4}.
  - Single slot_load = 0001 with slot_x = 40 and slot_bits = rom_data.
  - slot_valid = 0001 in DONE.
  - busy lasts 21 cycles.
- Sprites 1, 2, 5, 9, 12 all at y = vpos + 1 → slots 0..3 load sprites 1, 2, 5, 9 in order; overflow = 1; slot_valid = 1111.
- No sprite on the line (all y = 200, vpos = 10) → no slot_load, slot_valid = 0000, busy for 19 cycles, overflow = 0.
- vpos = 261, sprite y = 255 → row = 7, hit. Same sprite with vpos = 262 (next_line = 263) → no hit.
- Reset asserted on the 5th SCAN cycle → next cycle IDLE with all outputs 0. The next hpos = 256 trigger performs a complete scan with correct results.
